// File: rtl/mem_byte_ctrl_if.sv
// CPU request/response and byte-RAM signals of the byte-serial memory controller.
// The slave modport is the controller; the master modport is the CPU plus RAM side.
interface mem_byte_ctrl_if #(
   parameter int MADDR_SZ = 32
);
   logic                req_valid;
   logic                req_ready;
   logic                req_we;
   logic [1:0]          req_size;
   logic                req_signed;
   logic [MADDR_SZ-1:0] req_addr;
   logic [63:0]         req_wdata;
   logic                resp_valid;
   logic                resp_err;
   logic [63:0]         resp_rdata;
   logic [MADDR_SZ-1:0] ram_addr;
   logic [7:0]          ram_datain;
   logic                ram_we;
   logic [7:0]          ram_dataout;

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, ram_dataout,
      output req_ready, resp_valid, resp_err, resp_rdata, ram_addr, ram_datain, ram_we
   );

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, ram_dataout,
      input  req_ready, resp_valid, resp_err, resp_rdata, ram_addr, ram_datain, ram_we
   );
endinterface

// File: rtl/mem_byte_ctrl.sv
// Sequences one aligned 1/2/4/8-byte big-endian load/store as single-byte RAM accesses.
// Load: N+1 cycles, store: 2N+1 cycles, misaligned: 1 cycle; req_ready only in IDLE, no response backpressure.
module mem_byte_ctrl #(
   parameter int MADDR_SZ = 32,
   parameter int DATA_SZ  = 64
) (
   input logic              clk,
   input logic              rst,
   mem_byte_ctrl_if.slave   bus
);
   typedef enum logic [2:0] {S_IDLE, S_RD, S_WR_SETUP, S_WR_STROBE, S_RESP} state_t;

   state_t               state_q;
   logic [2:0]           cnt_q;
   logic [1:0]           size_q;
   logic                 signed_q;
   logic [DATA_SZ-1:0]   sr_q;
   logic                 ready_q;
   logic                 resp_valid_q;
   logic                 resp_err_q;
   logic [DATA_SZ-1:0]   resp_rdata_q;
   logic [MADDR_SZ-1:0]  ram_addr_q;
   logic [7:0]           ram_datain_q;
   logic                 ram_we_q;

   logic [2:0]           req_mask;
   logic                 req_misaligned;
   logic [DATA_SZ-1:0]   wr_sr_d;
   logic [DATA_SZ-1:0]   rd_sr_d;
   logic [DATA_SZ-1:0]   rdata_d;
   logic                 last_byte;

   function automatic logic [2:0] size_mask(input logic [1:0] s);
      case (s)
         2'd0:    size_mask = 3'd0;
         2'd1:    size_mask = 3'd1;
         2'd2:    size_mask = 3'd3;
         default: size_mask = 3'd7;
      endcase
   endfunction

   assign req_mask       = size_mask(bus.req_size);
   assign req_misaligned = |(bus.req_addr[2:0] & req_mask);
   // Store data is left-justified so the next outgoing byte is always the top byte.
   assign wr_sr_d        = bus.req_wdata << {3'd7 - req_mask, 3'b000};
   assign rd_sr_d        = {sr_q[DATA_SZ-9:0], bus.ram_dataout};
   assign last_byte      = (cnt_q == size_mask(size_q));

   always_comb begin
      rdata_d = '0;
      case (size_q)
         2'd0:    rdata_d = {{56{signed_q & rd_sr_d[7]}},  rd_sr_d[7:0]};
         2'd1:    rdata_d = {{48{signed_q & rd_sr_d[15]}}, rd_sr_d[15:0]};
         2'd2:    rdata_d = {{32{signed_q & rd_sr_d[31]}}, rd_sr_d[31:0]};
         default: rdata_d = rd_sr_d;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         size_q       <= '0;
         signed_q     <= 1'b0;
         sr_q         <= '0;
         ready_q      <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         ram_addr_q   <= '0;
         ram_datain_q <= '0;
         ram_we_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.req_valid && ready_q) begin
                  ready_q  <= 1'b0;
                  size_q   <= bus.req_size;
                  signed_q <= bus.req_signed;
                  cnt_q    <= '0;
                  if (req_misaligned) begin
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= '0;
                     state_q      <= S_RESP;
                  end else begin
                     ram_addr_q <= bus.req_addr;
                     if (bus.req_we) begin
                        sr_q         <= wr_sr_d;
                        ram_datain_q <= wr_sr_d[DATA_SZ-1:DATA_SZ-8];
                        state_q      <= S_WR_SETUP;
                     end else begin
                        sr_q    <= '0;
                        state_q <= S_RD;
                     end
                  end
               end
            end
            S_RD: begin
               sr_q       <= rd_sr_d;
               cnt_q      <= cnt_q + 3'd1;
               ram_addr_q <= ram_addr_q + MADDR_SZ'(1);
               if (last_byte) begin
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b0;
                  resp_rdata_q <= rdata_d;
                  state_q      <= S_RESP;
               end
            end
            S_WR_SETUP: begin
               ram_we_q <= 1'b1;
               state_q  <= S_WR_STROBE;
            end
            S_WR_STROBE: begin
               ram_we_q <= 1'b0;
               if (last_byte) begin
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b0;
                  resp_rdata_q <= '0;
                  state_q      <= S_RESP;
               end else begin
                  cnt_q        <= cnt_q + 3'd1;
                  ram_addr_q   <= ram_addr_q + MADDR_SZ'(1);
                  sr_q         <= sr_q << 8;
                  ram_datain_q <= sr_q[DATA_SZ-9:DATA_SZ-16];
                  state_q      <= S_WR_SETUP;
               end
            end
            S_RESP: begin
               resp_valid_q <= 1'b0;
               ready_q      <= 1'b1;
               state_q      <= S_IDLE;
            end
            default: begin
               ready_q <= 1'b1;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready  = ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.ram_addr   = ram_addr_q;
   assign bus.ram_datain = ram_datain_q;
   assign bus.ram_we     = ram_we_q;
endmodule

// File: tb/tb_mem_byte_ctrl.sv
// Scoreboard bench: a byte-RAM model plus an array-based reference memory predicting responses and RAM writes.
module tb_mem_byte_ctrl;
   logic clk;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   passes = 0;

   mem_byte_ctrl_if #(.MADDR_SZ(32)) bus ();

   mem_byte_ctrl #(.MADDR_SZ(32), .DATA_SZ(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        err;
      logic [63:0] rdata;
      int          cyc;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  data;
   } wr_t;

   exp_t exp_q[$];
   wr_t  wq[$];
   exp_t mon_e;
   wr_t  mon_w;

   logic [7:0] ram_mem [256];
   logic [7:0] ref_mem [256];

   int last_c = 0;
   int last_lat = 0;
   bit prev_hold = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      $display("FAIL %s: timed out at cycle %0d", name, cyc);
   endtask

   // Asynchronous-read RAM that writes on the rising edge of we.
   assign bus.ram_dataout = ram_mem[bus.ram_addr[7:0]];

   always @(posedge bus.ram_we) begin
      ram_mem[bus.ram_addr[7:0]] = bus.ram_datain;
      if (wq.size() == 0) begin
         timeout_fail("unexpected_ram_write");
      end else begin
         mon_w = wq.pop_front();
         chk("ram_wr_addr", 64'(bus.ram_addr), 64'(mon_w.addr));
         chk("ram_wr_data", 64'(bus.ram_datain), 64'(mon_w.data));
      end
   end

   always @(negedge clk) begin
      if (bus.resp_valid) begin
         if (exp_q.size() == 0) begin
            timeout_fail("unexpected_response");
         end else begin
            mon_e = exp_q.pop_front();
            chk("resp_err", 64'(bus.resp_err), 64'(mon_e.err));
            chk("resp_rdata", bus.resp_rdata, mon_e.rdata);
            chk("resp_cycle", 64'(cyc), 64'(mon_e.cyc));
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [63:0] wdata, input bit hold);
      int n, lat, c;
      logic [63:0] v;
      exp_t e;
      wr_t  w;
      bit misal;
      n = 1 << size;
      misal = (addr % n) != 0;
      bus.req_we = we;
      bus.req_size = size;
      bus.req_signed = sgn;
      bus.req_addr = addr;
      bus.req_wdata = wdata;
      bus.req_valid = 1'b1;
      for (int k = 0; k < 100 && !bus.req_ready; k++) @(negedge clk);
      if (!bus.req_ready) begin
         timeout_fail("accept");
         bus.req_valid = 1'b0;
         prev_hold = 0;
         return;
      end
      c = cyc;
      if (prev_hold) chk("b2b_accept_cycle", 64'(c), 64'(last_c + last_lat + 1));
      v = '0;
      if (misal) begin
         lat = 1;
      end else if (we) begin
         lat = 2 * n + 1;
         for (int i = 0; i < n; i++) begin
            w.addr = addr + 32'(i);
            w.data = 8'(wdata >> (8 * (n - 1 - i)));
            ref_mem[w.addr[7:0]] = w.data;
            wq.push_back(w);
         end
      end else begin
         lat = n + 1;
         for (int i = 0; i < n; i++) v = (v << 8) | 64'(ref_mem[8'(addr + 32'(i))]);
         if (sgn && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
      end
      e.err = misal;
      e.rdata = v;
      e.cyc = c + lat;
      exp_q.push_back(e);
      last_c = c;
      last_lat = lat;
      prev_hold = hold;
      @(negedge clk);
      chk("ready_low_after_accept", 64'(bus.req_ready), 64'd0);
      if (!hold) bus.req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 200 && (exp_q.size() != 0 || wq.size() != 0); k++) @(negedge clk);
      if (exp_q.size() != 0 || wq.size() != 0) timeout_fail("drain");
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] ra;
      logic [1:0]  rs;
      logic [63:0] wd;
      bit          hd;
      rst = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_we = 1'b0;
      bus.req_size = 2'd0;
      bus.req_signed = 1'b0;
      bus.req_addr = '0;
      bus.req_wdata = '0;
      for (int i = 0; i < 256; i++) ram_mem[i] = 8'($urandom);
      for (int i = 0; i < 8; i++) ram_mem[16 + i] = 8'(i + 1);
      ram_mem[7] = 8'h80;
      for (int i = 0; i < 256; i++) ref_mem[i] = ram_mem[i];

      repeat (3) @(negedge clk);
      chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
      chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("rst_resp_err", 64'(bus.resp_err), 64'd0);
      chk("rst_resp_rdata", bus.resp_rdata, 64'd0);
      chk("rst_ram_addr", 64'(bus.ram_addr), 64'd0);
      chk("rst_ram_datain", 64'(bus.ram_datain), 64'd0);
      chk("rst_ram_we", 64'(bus.ram_we), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      issue(1'b0, 2'd3, 1'b0, 32'h10, 64'd0, 1'b0);
      wait_idle();
      chk("dword_load_const", bus.resp_rdata, 64'h0102030405060708);
      issue(1'b0, 2'd0, 1'b1, 32'h7, 64'd0, 1'b0);
      wait_idle();
      chk("byte_load_signed_const", bus.resp_rdata, 64'hFFFFFFFFFFFFFF80);
      issue(1'b0, 2'd0, 1'b0, 32'h7, 64'd0, 1'b0);
      wait_idle();
      chk("byte_load_unsigned_const", bus.resp_rdata, 64'h80);

      issue(1'b1, 2'd2, 1'b0, 32'h20, 64'hA5A5A5A5DEADBEEF, 1'b0);
      wait_idle();
      issue(1'b0, 2'd2, 1'b0, 32'h20, 64'd0, 1'b0);
      wait_idle();
      chk("word_readback_const", bus.resp_rdata, 64'hDEADBEEF);

      issue(1'b0, 2'd1, 1'b0, 32'h3, 64'd0, 1'b0);
      wait_idle();
      chk("misaligned_err", 64'(bus.resp_err), 64'd1);
      chk("misaligned_ram_addr_kept", 64'(bus.ram_addr), 64'h24);

      // Dword store at 0x40 aborted by reset during the setup of byte 2.
      for (int k = 0; k < 20 && !bus.req_ready; k++) @(negedge clk);
      wd = {$urandom, $urandom};
      bus.req_we = 1'b1;
      bus.req_size = 2'd3;
      bus.req_signed = 1'b0;
      bus.req_addr = 32'h40;
      bus.req_wdata = wd;
      bus.req_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         mon_w.addr = 32'h40 + 32'(i);
         mon_w.data = 8'(wd >> (8 * (7 - i)));
         ref_mem[mon_w.addr[7:0]] = mon_w.data;
         wq.push_back(mon_w);
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("abort_setup_addr", 64'(bus.ram_addr), 64'h42);
      chk("abort_setup_we", 64'(bus.ram_we), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_ram_we", 64'(bus.ram_we), 64'd0);
      chk("abort_req_ready", 64'(bus.req_ready), 64'd1);
      chk("abort_resp_valid", 64'(bus.resp_valid), 64'd0);
      repeat (20) @(negedge clk);
      chk("abort_writes_done", 64'(wq.size()), 64'd0);
      issue(1'b0, 2'd3, 1'b0, 32'h40, 64'd0, 1'b0);
      wait_idle();

      issue(1'b0, 2'd2, 1'b1, 32'h10, 64'd0, 1'b1);
      issue(1'b0, 2'd1, 1'b0, 32'h12, 64'd0, 1'b0);
      wait_idle();

      for (int t = 0; t < 150; t++) begin
         rs = 2'($urandom_range(0, 3));
         ra = 32'($urandom_range(0, 255));
         if ($urandom_range(0, 3) != 0) ra = ra & ~32'((1 << rs) - 1);
         hd = (t != 149) && ($urandom_range(0, 1) == 1);
         issue(1'($urandom), rs, 1'($urandom), ra, {$urandom, $urandom}, hd);
      end
      wait_idle();
      chk("writes_drained", 64'(wq.size()), 64'd0);
      chk("responses_drained", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
